// File: rtl/siganfu_gatling_controller_if.sv
// -----------------------------------------------------------------------------
// siganfu_gatling_controller_if
//
// Purpose: groups the turret's sensor/command inputs and its status outputs
// into one bundle so the controller and its environment share a single port.
//
// Signal summary:
//   target_locked, is_enemy       level  targeting qualifiers (ready = both high)
//   fire_command                  level  operator trigger
//   overheat_sensor               level  barrel temperature alarm
//   firing_mode[1:0]              level  00 single, 01 burst, 10 auto, 11 single
//   current_state[2:0]            out    registered controller state
//   fire_trigger                  out    one round fired per cycle while high
//   criticality_alert             out    high in OVERHEAT or EMPTY
//   rounds_left                   out    rounds remaining in current magazine
//   mags_left                     out    spare magazines remaining
//
// Modports:
//   slave  - the controller (consumes inputs, drives status)
//   master - the environment (drives inputs, observes status)
// -----------------------------------------------------------------------------
interface siganfu_gatling_controller_if #(
    parameter int MAG_SIZE  = 25,
    parameter int MAG_COUNT = 2
);
    localparam int RW = $clog2(MAG_SIZE + 1);
    localparam int MW = $clog2(MAG_COUNT + 1);

    logic          target_locked;
    logic          is_enemy;
    logic          fire_command;
    logic          overheat_sensor;
    logic [1:0]    firing_mode;
    logic [2:0]    current_state;
    logic          fire_trigger;
    logic          criticality_alert;
    logic [RW-1:0] rounds_left;
    logic [MW-1:0] mags_left;

    modport slave (
        input  target_locked,
        input  is_enemy,
        input  fire_command,
        input  overheat_sensor,
        input  firing_mode,
        output current_state,
        output fire_trigger,
        output criticality_alert,
        output rounds_left,
        output mags_left
    );

    modport master (
        output target_locked,
        output is_enemy,
        output fire_command,
        output overheat_sensor,
        output firing_mode,
        input  current_state,
        input  fire_trigger,
        input  criticality_alert,
        input  rounds_left,
        input  mags_left
    );
endinterface

// File: rtl/siganfu_gatling_controller.sv
// -----------------------------------------------------------------------------
// siganfu_gatling_controller
//
// Purpose: fire-control FSM for a gatling turret. Fires one round per cycle
// in FIRING, supports single / burst / auto modes, reloads from a limited
// stock of spare magazines, and locks out on overheat until the sensor has
// stayed low for COOLDOWN_CYCLES consecutive cycles.
//
// Ports:
//   sysclk  in   system clock, rising edge
//   reboot  in   asynchronous active-high reset
//   gun     siganfu_gatling_controller_if.slave (inputs and status outputs)
//
// Configuration macro:
//   SIGANFU_MAG_LIMIT_EN  defined   -> spare magazines are consumed on each
//                                      reload; EMPTY is entered when the last
//                                      round goes with no spare left.
//                         undefined -> reloads are unlimited, EMPTY is never
//                                      reached, mags_left holds MAG_COUNT.
//
// Handshake semantics: there is no valid/ready pair here. "ready" is a level
// qualifier (target_locked & is_enemy) sampled on every rising edge; all
// inputs are levels and every output is a Moore decode of registered state.
// -----------------------------------------------------------------------------
module siganfu_gatling_controller #(
    parameter int MAG_SIZE        = 25,
    parameter int MAG_COUNT       = 2,
    parameter int RELOAD_CYCLES   = 5,
    parameter int COOLDOWN_CYCLES = 10,
    parameter int BURST_LEN       = 3
) (
    input  logic                           sysclk,
    input  logic                           reboot,
    siganfu_gatling_controller_if.slave    gun
);
    localparam int RW  = $clog2(MAG_SIZE + 1);
    localparam int MW  = $clog2(MAG_COUNT + 1);
    localparam int BW  = $clog2(BURST_LEN + 1);
    localparam int RCW = $clog2(RELOAD_CYCLES + 1);
    localparam int CW  = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [RW-1:0]  MAG_FULL    = RW'(MAG_SIZE);
    localparam logic [RW-1:0]  LAST_ROUND  = RW'(1);
    localparam logic [MW-1:0]  MAGS_FULL   = MW'(MAG_COUNT);
    localparam logic [BW-1:0]  BURST_BUDGET = BW'(BURST_LEN);
    localparam logic [BW-1:0]  ONE_SHOT    = BW'(1);
    localparam logic [RCW-1:0] RELOAD_LAST = RCW'(RELOAD_CYCLES - 1);
    localparam logic [CW-1:0]  COOL_LAST   = CW'(COOLDOWN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        READY    = 3'b001,
        FIRING   = 3'b010,
        RELOAD   = 3'b011,
        OVERHEAT = 3'b100,
        EMPTY    = 3'b101
    } state_t;

    state_t         state_q,  state_d;
    logic [RW-1:0]  rounds_q, rounds_d;
    logic [MW-1:0]  mags_q,   mags_d;
    logic [BW-1:0]  budget_q, budget_d;
    logic           auto_q,   auto_d;
    logic           armed_q,  armed_d;
    logic [RCW-1:0] reload_q, reload_d;
    logic [CW-1:0]  cool_q,   cool_d;

    logic ready;
    logic have_spare;

    assign ready = gun.target_locked & gun.is_enemy;

`ifdef SIGANFU_MAG_LIMIT_EN
    assign have_spare = (mags_q != '0);
`else
    assign have_spare = 1'b1;
`endif

    always_ff @(posedge sysclk or posedge reboot) begin
        if (reboot) begin
            state_q  <= IDLE;
            rounds_q <= MAG_FULL;
            mags_q   <= MAGS_FULL;
            budget_q <= '0;
            auto_q   <= 1'b0;
            armed_q  <= 1'b1;
            reload_q <= '0;
            cool_q   <= '0;
        end else begin
            state_q  <= state_d;
            rounds_q <= rounds_d;
            mags_q   <= mags_d;
            budget_q <= budget_d;
            auto_q   <= auto_d;
            armed_q  <= armed_d;
            reload_q <= reload_d;
            cool_q   <= cool_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rounds_d = rounds_q;
        mags_d   = mags_q;
        budget_d = budget_q;
        auto_d   = auto_q;
        armed_d  = armed_q;
        // Reload and cooldown counters only run inside their own state, so
        // every entry starts them from zero.
        reload_d = '0;
        cool_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (!gun.fire_command) armed_d = 1'b1;
                if (ready) state_d = READY;
            end

            READY: begin
                if (!gun.fire_command) armed_d = 1'b1;
                if (gun.overheat_sensor) begin
                    state_d = OVERHEAT;
                end else if (!ready) begin
                    state_d = IDLE;
                end else if (gun.fire_command && armed_q) begin
                    state_d  = FIRING;
                    auto_d   = (gun.firing_mode == 2'b10);
                    budget_d = (gun.firing_mode == 2'b01) ? BURST_BUDGET :
                               (gun.firing_mode == 2'b10) ? '0 : ONE_SHOT;
                end
            end

            FIRING: begin
                if (rounds_q != '0) rounds_d = rounds_q - 1'b1;
                if (budget_q != '0) budget_d = budget_q - 1'b1;
                // Single/burst disarm for as long as they fire, so whatever
                // ends the volley (completion, overheat, target loss, reload)
                // a fresh trigger press is needed before the next one.
                if (!auto_q) armed_d = 1'b0;

                if (gun.overheat_sensor) begin
                    state_d = OVERHEAT;
                end else if (rounds_q == LAST_ROUND) begin
                    state_d = have_spare ? RELOAD : EMPTY;
                end else if (!ready) begin
                    state_d = IDLE;
                end else if (auto_q ? !gun.fire_command : (budget_q == ONE_SHOT)) begin
                    state_d = READY;
                end
            end

            RELOAD: begin
                reload_d = reload_q + 1'b1;
                if (reload_q == RELOAD_LAST) begin
                    reload_d = '0;
                    rounds_d = MAG_FULL;
`ifdef SIGANFU_MAG_LIMIT_EN
                    if (mags_q != '0) mags_d = mags_q - 1'b1;
`endif
                    if (gun.overheat_sensor) state_d = OVERHEAT;
                    else if (ready)          state_d = READY;
                    else                     state_d = IDLE;
                end
            end

            OVERHEAT: begin
                if (!gun.overheat_sensor) begin
                    cool_d = cool_q + 1'b1;
                    if (cool_q == COOL_LAST) begin
                        cool_d = '0;
                        // Overheat can pre-empt the magazine-out transition on
                        // the very last round; finish that reload here so the
                        // gun never sits in READY/IDLE with an empty magazine.
                        if (rounds_q == '0)  state_d = have_spare ? RELOAD : EMPTY;
                        else if (ready)      state_d = READY;
                        else                 state_d = IDLE;
                    end
                end
            end

            EMPTY: begin
                rounds_d = '0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifndef SIGANFU_MAG_LIMIT_EN
        mags_d = MAGS_FULL;
`endif
    end

    assign gun.current_state     = state_q;
    assign gun.fire_trigger      = (state_q == FIRING);
    assign gun.criticality_alert = (state_q == OVERHEAT) || (state_q == EMPTY);
    assign gun.rounds_left       = rounds_q;
    assign gun.mags_left         = mags_q;

endmodule
